// File: rtl/iir_orde1_mc_pkg.sv
// iir_orde1_pkg: shared FSM states, default widths and rounding/saturation helpers for iir_orde1_mc.
package iir_orde1_pkg;
  typedef enum logic [1:0] {IDLE, MUL, SUM, HOLD} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_COEF_FRAC = 15;
  localparam int DEF_NUM_CH = 2;
  function automatic longint rnd_const(input int frac);
    return (frac > 0) ? (longint'(1) << (frac - 1)) : longint'(0);
  endfunction
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/iir_orde1_mc_if.sv
// iir_orde1_mc_if: valid/ready sample stream in and filtered stream out, with channel tags.
interface iir_orde1_mc_if #(parameter int DATA_W = 16, parameter int CH_W = 1);
  logic s_valid;
  logic s_ready;
  logic [CH_W-1:0] s_ch;
  logic signed [DATA_W-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic [CH_W-1:0] m_ch;
  logic signed [DATA_W-1:0] m_data;
  modport master (output s_valid, s_ch, s_data, m_ready, input s_ready, m_valid, m_ch, m_data);
  modport slave (input s_valid, s_ch, s_data, m_ready, output s_ready, m_valid, m_ch, m_data);
endinterface

// File: rtl/iir_orde1_mc_round_sat.sv
// iir_round_sat: round-half-up, shift out fractional bits, then saturate (IIR_ORDE1_MC_SAT_EN) or wrap.
module iir_round_sat import iir_orde1_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_DATA_W + DEF_COEF_W + 2,
  parameter int COEF_FRAC = DEF_COEF_FRAC
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y,
  output logic                     clip
);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(rnd_const(COEF_FRAC));
`ifdef IIR_ORDE1_MC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(sat_max(DATA_W));
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(sat_min(DATA_W));
  logic signed [ACC_W-1:0] sh;
  always_comb begin
    sh = (acc + RND) >>> COEF_FRAC;
    clip = (sh > MAXV) || (sh < MINV);
    y = (sh > MAXV) ? DATA_W'(MAXV) : (sh < MINV) ? DATA_W'(MINV) : DATA_W'(sh);
  end
`else
  assign y = DATA_W'((acc + RND) >>> COEF_FRAC);
  assign clip = 1'b0;
`endif
endmodule

// File: rtl/iir_orde1_mc.sv
// iir_orde1_mc: NUM_CH-channel first-order IIR sharing one MAC over IDLE/MUL/SUM/HOLD.
// Build with IIR_ORDE1_MC_SAT_EN for saturating output and a live sat_flag; otherwise outputs wrap.
module iir_orde1_mc import iir_orde1_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int COEF_FRAC = DEF_COEF_FRAC,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ACC_W = DATA_W + COEF_W + 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clear_state,
  input  logic [NUM_CH*COEF_W-1:0]   coef_a0,
  input  logic [NUM_CH*COEF_W-1:0]   coef_a1,
  input  logic [NUM_CH*COEF_W-1:0]   coef_b1,
  iir_orde1_mc_if.slave              io,
  output logic                       sat_flag,
  output logic                       ch_err
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = DATA_W + COEF_W;
  localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);
  state_t state, nxt;
  logic up, ok, hs, clip;
  logic [CH_W-1:0] ch, sel, mc;
  logic signed [DATA_W-1:0] x, xp, yp, md, y;
  logic signed [COEF_W-1:0] c0, c1, c2;
  logic signed [PW-1:0] p0, p1, p2;
  logic signed [ACC_W-1:0] acc;
  logic signed [DATA_W-1:0] xh [NUM_CH];
  logic signed [DATA_W-1:0] yh [NUM_CH];
  assign ok = {1'b0, io.s_ch} < NCH;
  assign sel = ok ? io.s_ch : '0;
  // up keeps s_ready low until the first edge after reset release
  assign io.s_ready = en && up && (state == IDLE);
  assign hs = io.s_valid && io.s_ready;
  assign io.m_valid = (state == HOLD);
  assign io.m_ch = mc;
  assign io.m_data = md;
  assign acc = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2);
  iir_round_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W), .COEF_FRAC(COEF_FRAC)) u_rs (
    .acc(acc), .y(y), .clip(clip)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = clear_state ? IDLE : !en ? state :
          (state == IDLE) ? ((hs && ok) ? MUL : IDLE) :
          (state == MUL) ? SUM :
          (state == SUM) ? HOLD :
          io.m_ready ? IDLE : HOLD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up <= 1'b0;
      ch <= '0; mc <= '0; x <= '0; xp <= '0; yp <= '0; md <= '0;
      c0 <= '0; c1 <= '0; c2 <= '0; p0 <= '0; p1 <= '0; p2 <= '0;
      sat_flag <= 1'b0; ch_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin xh[i] <= '0; yh[i] <= '0; end
    end else begin
      up <= 1'b1;
      if (clear_state) begin
        sat_flag <= 1'b0; ch_err <= 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin xh[i] <= '0; yh[i] <= '0; end
      end else if (en) begin
        if (hs && ok) begin
          ch <= sel; x <= io.s_data; xp <= xh[sel]; yp <= yh[sel];
          c0 <= coef_a0[sel*COEF_W +: COEF_W];
          c1 <= coef_a1[sel*COEF_W +: COEF_W];
          c2 <= coef_b1[sel*COEF_W +: COEF_W];
        end
        if (hs && !ok) ch_err <= 1'b1;
        if (state == MUL) begin
          p0 <= PW'(c0) * PW'(x);
          p1 <= PW'(c1) * PW'(xp);
          p2 <= PW'(c2) * PW'(yp);
        end
        // history is committed here so a same-channel sample accepted after HOLD sees it
        if (state == SUM) begin
          md <= y; mc <= ch; xh[ch] <= x; yh[ch] <= y;
          sat_flag <= sat_flag | clip;
        end
      end
    end
  end
endmodule

// File: tb/tb_iir_orde1_mc.sv
// tb_iir_orde1_mc: directed tests of the multi-channel IIR with hand-computed expectations.
module tb_iir_orde1_mc;
  logic clk, rst_n, en, clear_state, sat_flag, ch_err;
  logic [47:0] coef_a0, coef_a1, coef_b1;
  int ca0 [3], ca1 [3], cb1 [3];
  int mx [3], my [3];
  int vec = 0, errs = 0, lat = 0;
  iir_orde1_mc_if #(.DATA_W(16), .CH_W(2)) io();
  iir_orde1_mc #(.NUM_CH(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear_state(clear_state),
    .coef_a0(coef_a0), .coef_a1(coef_a1), .coef_b1(coef_b1),
    .io(io), .sat_flag(sat_flag), .ch_err(ch_err)
  );
  assign coef_a0 = {16'(ca0[2]), 16'(ca0[1]), 16'(ca0[0])};
  assign coef_a1 = {16'(ca1[2]), 16'(ca1[1]), 16'(ca1[0])};
  assign coef_b1 = {16'(cb1[2]), 16'(cb1[1]), 16'(cb1[0])};
  initial clk = 0;
  always #5 clk = ~clk;

  task automatic model(input int c, input int x, output int y);
    longint s;
    logic signed [15:0] t;
    s = longint'(ca0[c]) * x + longint'(ca1[c]) * mx[c] + longint'(cb1[c]) * my[c] + 16384;
    s = s >>> 15;
`ifdef IIR_ORDE1_MC_SAT_EN
    y = (s > 32767) ? 32767 : (s < -32768) ? -32768 : int'(s);
`else
    t = 16'(s);
    y = t;
`endif
    mx[c] = x; my[c] = y;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin mx[i] = 0; my[i] = 0; end
  endtask

  task automatic pulse_clear();
    clear_state = 1; @(posedge clk); #1; clear_state = 0;
    model_clear();
  endtask

  task automatic wait_mv(input string nm);
    int n = 0;
    while (!io.m_valid && n < 12) begin @(posedge clk); #1; n++; end
    lat = n;
    if (!io.m_valid) begin errs++; $display("FAIL %s timeout: m_valid=%b required 1", nm, io.m_valid); end
  endtask

  task automatic xfer(input logic [1:0] c, input int d, output int y, output logic [1:0] yc);
    int n = 0;
    io.s_valid = 1; io.s_ch = c; io.s_data = 16'(d);
    while (!io.s_ready && n < 12) begin @(posedge clk); #1; n++; end
    if (!io.s_ready) begin errs++; $display("FAIL xfer_accept timeout: s_ready=%b required 1", io.s_ready); end
    @(posedge clk); #1;
    io.s_valid = 0;
    wait_mv("xfer_out");
    y = int'(io.m_data); yc = io.m_ch;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    vec++;
    if ({io.m_valid, io.s_ready, io.m_data, io.m_ch, sat_flag, ch_err} !== 22'd0) begin
      errs++; $display("FAIL reset_outputs: mv=%b sr=%b md=%0d mc=%0d sat=%b err=%b required all 0",
        io.m_valid, io.s_ready, io.m_data, io.m_ch, sat_flag, ch_err);
    end
    @(posedge clk); #1; rst_n = 1;
    vec++;
    if (io.s_ready !== 1'b0) begin errs++; $display("FAIL ready_release_edge: s_ready=%b required 0", io.s_ready); end
    @(posedge clk); #1;
    vec++;
    if (io.s_ready !== 1'b1) begin errs++; $display("FAIL ready_after_reset: s_ready=%b required 1", io.s_ready); end
  endtask

  task automatic test_step();
    int y, e, prev;
    int hand [3] = '{208, 413, 616};
    logic [1:0] yc;
    ca0[0] = 426; ca1[0] = 0; cb1[0] = 32342;
    prev = -32768;
    for (int i = 0; i < 1000; i++) begin
      xfer(2'd0, 16000, y, yc);
      model(0, 16000, e);
      if (i == 0) begin
        vec++;
        if (lat !== 2) begin errs++; $display("FAIL latency: edges_after_accept=%0d required 3", lat + 1); end
      end
      if (i < 3) begin
        vec++;
        if (y !== hand[i]) begin errs++; $display("FAIL step_hand[%0d]: got %0d required %0d", i, y, hand[i]); end
      end
      vec++;
      if (y !== e || yc !== 2'd0 || y < prev) begin
        errs++; $display("FAIL step[%0d]: got %0d ch %0d prev %0d required %0d ch 0 monotonic", i, y, yc, prev, e);
      end
      prev = y;
    end
    vec++;
    if (prev < 16000 - 64 || prev > 16000 + 64) begin errs++; $display("FAIL step_final: got %0d required 16000+-64", prev); end
  endtask

  task automatic test_isolation();
    int y, e;
    logic [1:0] yc;
    pulse_clear();
    ca0[1] = 0; ca1[1] = 16384; cb1[1] = 0;
    for (int i = 0; i < 8; i++) begin
      xfer(2'd0, 16000, y, yc);
      model(0, 16000, e);
      vec++;
      if (y !== e || yc !== 2'd0 || (i == 0 && y !== 208)) begin
        errs++; $display("FAIL iso_ch0[%0d]: got %0d ch %0d required %0d ch 0", i, y, yc, e);
      end
      xfer(2'd1, 0, y, yc);
      model(1, 0, e);
      vec++;
      if (y !== 0 || yc !== 2'd1) begin errs++; $display("FAIL iso_ch1[%0d]: got %0d ch %0d required 0 ch 1", i, y, yc); end
    end
  endtask

  task automatic test_xprev();
    int y, e;
    logic [1:0] yc;
    int xs [3] = '{1000, 2000, -3000};
    int hand [3] = '{0, 500, 1000};
    for (int i = 0; i < 3; i++) begin
      xfer(2'd1, xs[i], y, yc);
      model(1, xs[i], e);
      vec++;
      if (y !== hand[i] || yc !== 2'd1) begin errs++; $display("FAIL xprev[%0d]: got %0d ch %0d required %0d ch 1", i, y, yc, hand[i]); end
    end
  endtask

  task automatic test_sat();
    int y, e;
    logic [1:0] yc;
    ca0[2] = 32767; ca1[2] = 0; cb1[2] = 32767;
    xfer(2'd2, 32767, y, yc);
    model(2, 32767, e);
    vec++;
    if (y !== 32766 || sat_flag !== 1'b0 || yc !== 2'd2) begin
      errs++; $display("FAIL sat_first: got %0d sat %b required 32766 sat 0", y, sat_flag);
    end
    xfer(2'd2, 32767, y, yc);
    model(2, 32767, e);
    vec++;
`ifdef IIR_ORDE1_MC_SAT_EN
    if (y !== 32767 || sat_flag !== 1'b1) begin errs++; $display("FAIL sat_second: got %0d sat %b required 32767 sat 1", y, sat_flag); end
`else
    if (y !== -5 || sat_flag !== 1'b0) begin errs++; $display("FAIL wrap_second: got %0d sat %b required -5 sat 0", y, sat_flag); end
`endif
  endtask

  task automatic test_backpressure();
    int e;
    pulse_clear();
    io.m_ready = 0;
    io.s_valid = 1; io.s_ch = 2'd0; io.s_data = 16'sd16000;
    @(posedge clk); #1;
    io.s_valid = 0;
    model(0, 16000, e);
    wait_mv("bp_out");
    for (int i = 0; i < 10; i++) begin
      vec++;
      if (io.m_valid !== 1'b1 || io.m_data !== 16'(e) || io.m_ch !== 2'd0 || io.s_ready !== 1'b0) begin
        errs++; $display("FAIL bp_hold[%0d]: mv=%b md=%0d mc=%0d sr=%b required 1 %0d 0 0", i, io.m_valid, io.m_data, io.m_ch, io.s_ready, e);
      end
      @(posedge clk); #1;
    end
    io.m_ready = 1;
    @(posedge clk); #1;
    vec++;
    if (io.m_valid !== 1'b0 || io.s_ready !== 1'b1) begin
      errs++; $display("FAIL bp_release: mv=%b sr=%b required 0 1", io.m_valid, io.s_ready);
    end
  endtask

  task automatic test_enable();
    int e;
    io.m_ready = 0;
    io.s_valid = 1; io.s_ch = 2'd0; io.s_data = 16'sd16000;
    @(posedge clk); #1;
    io.s_valid = 0;
    model(0, 16000, e);
    wait_mv("en_out");
    en = 0; io.m_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (io.m_valid !== 1'b1 || io.m_data !== 16'(e) || io.s_ready !== 1'b0) begin
      errs++; $display("FAIL en_freeze: mv=%b md=%0d sr=%b required 1 %0d 0", io.m_valid, io.m_data, io.s_ready, e);
    end
    en = 1;
    @(posedge clk); #1;
    vec++;
    if (io.m_valid !== 1'b0 || io.s_ready !== 1'b1) begin errs++; $display("FAIL en_resume: mv=%b sr=%b required 0 1", io.m_valid, io.s_ready); end
  endtask

  task automatic test_ch_err();
    io.s_valid = 1; io.s_ch = 2'd3; io.s_data = 16'sd1234;
    @(posedge clk); #1;
    io.s_valid = 0;
    vec++;
    if (ch_err !== 1'b1 || io.s_ready !== 1'b1 || io.m_valid !== 1'b0) begin
      errs++; $display("FAIL ch_err: err=%b sr=%b mv=%b required 1 1 0", ch_err, io.s_ready, io.m_valid);
    end
    repeat (5) begin
      @(posedge clk); #1;
      vec++;
      if (io.m_valid !== 1'b0) begin errs++; $display("FAIL ch_err_no_out: m_valid=%b required 0", io.m_valid); end
    end
  endtask

  task automatic test_clear();
    int y, e;
    logic [1:0] yc;
    io.m_ready = 0;
    io.s_valid = 1; io.s_ch = 2'd0; io.s_data = 16'sd16000;
    @(posedge clk); #1;
    io.s_valid = 0;
    wait_mv("clr_out");
    clear_state = 1;
    @(posedge clk); #1;
    clear_state = 0; io.m_ready = 1;
    model_clear();
    vec++;
    if (io.m_valid !== 1'b0 || sat_flag !== 1'b0 || ch_err !== 1'b0) begin
      errs++; $display("FAIL clear_hold: mv=%b sat=%b err=%b required 0 0 0", io.m_valid, sat_flag, ch_err);
    end
    xfer(2'd0, 16000, y, yc);
    model(0, 16000, e);
    vec++;
    if (y !== 208) begin errs++; $display("FAIL clear_restart: got %0d required 208", y); end
  endtask

  task automatic test_async_reset();
    io.s_valid = 1; io.s_ch = 2'd0; io.s_data = 16'sd16000;
    @(posedge clk); #1;
    io.s_valid = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    vec++;
    if ({io.m_valid, io.s_ready, io.m_data, io.m_ch, sat_flag, ch_err} !== 22'd0) begin
      errs++; $display("FAIL async_reset: mv=%b sr=%b md=%0d mc=%0d sat=%b err=%b required all 0",
        io.m_valid, io.s_ready, io.m_data, io.m_ch, sat_flag, ch_err);
    end
    @(posedge clk); #1; rst_n = 1;
  endtask

  initial begin
    rst_n = 0; en = 1; clear_state = 0;
    io.s_valid = 0; io.s_ch = '0; io.s_data = '0; io.m_ready = 1;
    for (int i = 0; i < 3; i++) begin ca0[i] = 0; ca1[i] = 0; cb1[i] = 0; end
    model_clear();
    test_reset();
    test_step();
    test_isolation();
    test_xprev();
    test_sat();
    test_backpressure();
    test_enable();
    test_ch_err();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/iir_orde1_mc.md
# iir_orde1_mc

Time-multiplexed, multi-channel first-order IIR filter computing y[n] = a0·x[n] + a1·x[n-1] + b1·y[n-1] per channel, with independent coefficients and history for each channel.
- Parametrised successor of the single-channel core: generic data and coefficient widths, NUM_CH channels sharing one multiply/accumulate datapath, and valid/ready streaming on both sides.
- Sits between the audio sample source and downstream mixing/EQ blocks.

## Interface
- DATA_W, 16: sample width, signed.
- COEF_W, 16: coefficient width, signed.
- COEF_FRAC, 15: coefficient fractional bits (Q1.15 default).
- NUM_CH, 2: channel count, ≥1; CH_W = max(1, $clog2(NUM_CH)).
- ACC_W, DATA_W+COEF_W+2: accumulator width.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; 0 freezes the FSM and all registers.
- clear_state  in  1  synchronous clear of all histories and flags.
- coef_a0, coef_a1, coef_b1  in  NUM_CH*COEF_W each  per-channel coefficients; channel k occupies bits [k*COEF_W +: COEF_W].
- s_valid  in  1  input sample valid.
- s_ready  out  1  input ready.
- s_ch  in  CH_W  input channel index.
- s_data  in  DATA_W  input sample x[n].
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_ch  out  CH_W  output channel index.
- m_data  out  DATA_W  output sample y[n].
- sat_flag  out  1  sticky: an output saturated.
- ch_err  out  1  sticky: an out-of-range s_ch was accepted.

## Operation
- Per-channel history registers: x_prev[k] and y_prev[k], DATA_W each.
- FSM states:
  - IDLE: s_ready = en. On handshake, latch s_ch, s_data, and the selected channel's coefficients and history; go to MUL.
  - MUL: register the three signed products (DATA_W+COEF_W each); go to SUM.
  - SUM: sign-extend products to ACC_W, add them, add 2^(COEF_FRAC-1), arithmetic shift right by COEF_FRAC, saturate to DATA_W. Load m_data and m_ch, write x_prev[ch]=x and y_prev[ch]=y, go to HOLD.
  - HOLD: m_valid=1. On m_valid&&m_ready go to IDLE.
- s_ch ≥ NUM_CH: sample is accepted, no arithmetic is done, no output is produced, ch_err is set, FSM stays in IDLE.
- Coefficients are sampled at input acceptance. Coefficient changes take effect from the next sample.
- en=0: state and all outputs hold, s_ready=0. A pending output is not lost.
- clear_state, at a clock edge with en either value:
  - zero every history register, sat_flag and ch_err;
  - FSM goes to IDLE and any in-flight sample is discarded;
  - m_valid drops next cycle. This is the only permitted exception to valid stability.
- With m_valid high and m_ready low, m_data and m_ch hold stable.

## Timing
- Reset (async assert, sync release) clears:
  - m_valid=0, s_ready=0, m_data=0, m_ch=0;
  - sat_flag=0, ch_err=0;
  - all histories zero; FSM in IDLE.
- s_ready rises the first cycle after reset release when en=1.
- Latency: m_valid is high 3 edges after the input handshake edge (MUL, SUM, HOLD).
- Throughput: one sample per 4 cycles when m_ready stays high. s_ready is low from acceptance until the cycle after the output handshake.
- Same-channel back-to-back samples are safe. History is written in SUM, before the next accept.

## Configuration
- IIR_ORDE1_MC_SAT_EN defined: saturation to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat_flag is set on clip.
- Undefined: two's-complement wrap (low DATA_W bits of the shifted sum); sat_flag is tied 0.

## Structure
- Package iir_orde1_pkg holds:
  - FSM state enum (IDLE, MUL, SUM, HOLD);
  - default width constants;
  - function/localparams for the rounding constant and saturation bounds.
- One sub-module, iir_round_sat: ACC_W in, DATA_W out, plus a clip indicator. It contains the rounding, shift and the macro-controlled saturate/wrap.

## Test plan
- Step, ch0, a0=426, a1=0, b1=32342, x=16000 repeated -> outputs 208, 413, …, monotonic, ending within 64 of 16000 after 1000 samples.
- Channel isolation: ch0 step 16000, ch1 x=0 interleaved -> every ch1 output is 0; m_ch matches s_ch; ch0 sequence matches the step test.
- Saturation, a0=b1=32767, x=32767 -> first output 32766, second output 32767 with sat_flag=1. With the macro undefined, second output wraps negative and sat_flag=0.
- Backpressure: m_ready=0 for 10 cycles -> m_valid, m_data and m_ch stable, s_ready=0. Release -> exactly one output handshake, s_ready=1 the next cycle.
- clear_state asserted in HOLD -> m_valid=0 next cycle, flags cleared. The next ch0 step sample yields 208 again.
- Async rst_n asserted mid-SUM -> all outputs 0 immediately.
- s_ch=NUM_CH -> ch_err=1, no m_valid, s_ready high again the next cycle.
